// File: rtl/lp805x_syncrd_if.sv
// Read-port / byte-stream bundle for lp805x_syncrd.
// master: the reader (pops words, emits bytes); slave: the environment.
interface lp805x_syncrd_if #(
  parameter int DATA_W = 40
);
  logic              rrdy;
  logic [DATA_W-1:0] rdata;
  logic              rget;
  logic              flush;
  logic [7:0]        byte_o;
  logic              byte_vld;
  logic              byte_ack;
  logic [2:0]        bytes_left;
  logic              busy;

  modport master (
    input  rrdy, rdata, flush, byte_ack,
    output rget, byte_o, byte_vld,
    output bytes_left, busy
  );

  modport slave (
    output rrdy, rdata, flush, byte_ack,
    input  rget, byte_o, byte_vld,
    input  bytes_left, busy
  );
endinterface

// File: rtl/lp805x_syncrd.sv
// Word-to-byte reader behind lp805x_syncg (rclk domain).
// Ports: clk, rst (async high), bus (lp805x_syncrd_if.master):
//   rrdy/rdata/rget word pop, flush, byte_o/byte_vld/byte_ack
//   byte stream, bytes_left, busy.
// Option: define LP805X_SYNCRD_PREFETCH_EN for a one-word
//   prefetch slot giving zero-bubble back-to-back words.
module lp805x_syncrd #(
  parameter int DATA_W    = 40,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  lp805x_syncrd_if.master       bus
);
  localparam int NB = DATA_W / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     sel;
  logic              ack, last;
  logic              slot_free, rget;

`ifdef LP805X_SYNCRD_PREFETCH_EN
  logic [DATA_W-1:0] pf_q, pf_d;
  logic              pf_vld_q, pf_vld_d;
  assign slot_free = (state_q == IDLE) | ~pf_vld_q;
  assign bus.busy  = (state_q != IDLE) | pf_vld_q;
`else
  assign slot_free = (state_q == IDLE);
  assign bus.busy  = (state_q != IDLE);
`endif

  // rst gate keeps the pop strobe low while the block is held in reset
  assign rget = bus.rrdy & ~bus.flush
              & slot_free & ~rst;
  assign bus.rget = rget;

  assign ack  = bus.byte_ack & (state_q == SHIFT);
  assign last = (idx_q == IW'(NB - 1));
  assign sel  = LSB_FIRST ? idx_q
                          : IW'(NB - 1) - idx_q;

  assign bus.byte_vld = (state_q == SHIFT);
  assign bus.byte_o   = (state_q == SHIFT)
                      ? word_q[{sel, 3'b000} +: 8]
                      : 8'h00;
  assign bus.bytes_left = (state_q == SHIFT)
                        ? 3'(NB - int'(idx_q))
                        : 3'd0;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
`ifdef LP805X_SYNCRD_PREFETCH_EN
    pf_d     = pf_q;
    pf_vld_d = pf_vld_q;
`endif
    if (bus.flush) begin
      state_d = IDLE;
      idx_d   = '0;
`ifdef LP805X_SYNCRD_PREFETCH_EN
      pf_vld_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rget) begin
            word_d  = bus.rdata;
            idx_d   = '0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
`ifdef LP805X_SYNCRD_PREFETCH_EN
          if (rget) begin
            pf_d     = bus.rdata;
            pf_vld_d = 1'b1;
          end
`endif
          if (ack && !last) begin
            idx_d = idx_q + IW'(1);
          end else if (ack) begin
            idx_d = '0;
`ifdef LP805X_SYNCRD_PREFETCH_EN
            // a word popped on the last-byte edge
            // goes straight to the word register
            if (pf_vld_q) begin
              word_d   = pf_q;
              pf_vld_d = 1'b0;
            end else if (rget) begin
              word_d   = bus.rdata;
              pf_vld_d = 1'b0;
            end else begin
              state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
`ifdef LP805X_SYNCRD_PREFETCH_EN
      pf_q     <= '0;
      pf_vld_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
`ifdef LP805X_SYNCRD_PREFETCH_EN
      pf_q     <= pf_d;
      pf_vld_q <= pf_vld_d;
`endif
    end
  end
endmodule
